// File: rtl/temporizador_8bits.sv
// Loadable down-counter timer with one-shot and periodic (auto-reload) modes.
// Every output is registered. The terminal-count pulse coincides with the first post-expiry count.
module temporizador_8bits #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] valor,
  input  logic             modo,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_s;
  logic [WIDTH-1:0] reload_r;
  logic [WIDTH-1:0] reload_s;
  logic             mode_r;
  logic             mode_s;
  logic             tc_r;
  logic             tc_s;
  logic             busy_r;
  logic             done_r;

  // State and datapath registers; reset overrides load and enable
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      count_r  <= {WIDTH{1'b0}};
      reload_r <= {WIDTH{1'b0}};
      mode_r   <= 1'b0;
      tc_r     <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      count_r  <= count_s;
      reload_r <= reload_s;
      mode_r   <= mode_s;
      tc_r     <= tc_s;
      busy_r   <= (state_s == RUN);
      done_r   <= (state_s == DONE);
    end
  end

  // Next-state and next-count logic; load wins over enable in every state
  always_comb begin
    state_s  = state_r;
    count_s  = count_r;
    reload_s = reload_r;
    mode_s   = mode_r;
    tc_s     = 1'b0;
    if (load) begin
      count_s  = valor;
      reload_s = valor;
      mode_s   = modo;
      if (valor != {WIDTH{1'b0}}) begin
        state_s = RUN;
      end else begin
        state_s = IDLE;
      end
    end else begin
      case (state_r)
        RUN: begin
          if (enable) begin
            if (count_r > WIDTH'(1)) begin
              count_s = count_r - WIDTH'(1);
            end else if (count_r == WIDTH'(1)) begin
              tc_s = 1'b1;
              if (mode_r) begin
                count_s = reload_r;
              end else begin
                count_s = {WIDTH{1'b0}};
                state_s = DONE;
              end
            end else begin
              // A zero count in RUN is unreachable; park safely without a pulse.
              count_s = {WIDTH{1'b0}};
              state_s = IDLE;
            end
          end else begin
            state_s = RUN;
          end
        end
        IDLE: state_s = IDLE;
        DONE: state_s = DONE;
        default: begin
          state_s = IDLE;
          count_s = {WIDTH{1'b0}};
        end
      endcase
    end
  end

  assign count = count_r;
  assign tc    = tc_r;
  assign busy  = busy_r;
  assign done  = done_r;

endmodule

// File: tb/tb_temporizador_8bits.sv
// Scoreboard bench for temporizador_8bits: the stimulus process queues the expected
// post-edge outputs for each cycle, and a monitor pops and compares them after every edge.
module tb_temporizador_8bits;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic             enable;
  logic             load;
  logic [WIDTH-1:0] valor;
  logic             modo;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;
  logic             done;

  int n_vec;
  int n_bad;

  logic [WIDTH+2:0] exp_q[$];
  string            name_q[$];

  temporizador_8bits #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .load   (load),
    .valor  (valor),
    .modo   (modo),
    .count  (count),
    .tc     (tc),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one sample per cycle, 1 time unit after the rising edge
  always @(posedge clk) begin
    logic [WIDTH+2:0] e;
    logic [WIDTH+2:0] a;
    string            nm;
    #1;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {count, tc, busy, done};
      n_vec++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s: got count=%0d tc=%b busy=%b done=%b, expected count=%0d tc=%b busy=%b done=%b",
                 nm, a[WIDTH+2:3], a[2], a[1], a[0], e[WIDTH+2:3], e[2], e[1], e[0]);
      end
    end
  end

  task automatic step(input logic r, input logic l, input logic en,
                      input logic [WIDTH-1:0] v, input logic m,
                      input logic [WIDTH-1:0] ec, input logic et,
                      input logic eb, input logic ed, input string nm);
    @(negedge clk);
    reset  = r;
    load   = l;
    enable = en;
    valor  = v;
    modo   = m;
    exp_q.push_back({ec, et, eb, ed});
    name_q.push_back(nm);
  endtask

  initial begin
    n_vec  = 0;
    n_bad  = 0;
    reset  = 1'b0;
    load   = 1'b0;
    enable = 1'b0;
    valor  = 8'd0;
    modo   = 1'b0;

    // Initial reset
    step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "reset_init");

    // One-shot from 5
    step(1'b0, 1'b1, 1'b1, 8'd5, 1'b0, 8'd5, 1'b0, 1'b1, 1'b0, "os_load5");
    step(1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 8'd4, 1'b0, 1'b1, 1'b0, "os_4");
    step(1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 8'd3, 1'b0, 1'b1, 1'b0, "os_3");
    step(1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 8'd2, 1'b0, 1'b1, 1'b0, "os_2");
    step(1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 8'd1, 1'b0, 1'b1, 1'b0, "os_1");
    step(1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, "os_expire");
    step(1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, "os_done_hold1");
    step(1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, "os_done_hold2");

    // Periodic from 3; valor/modo wiggle without load must not matter
    step(1'b0, 1'b1, 1'b1, 8'd3, 1'b1, 8'd3, 1'b0, 1'b1, 1'b0, "per_load3");
    step(1'b0, 1'b0, 1'b1, 8'd7, 1'b0, 8'd2, 1'b0, 1'b1, 1'b0, "per_2");
    step(1'b0, 1'b0, 1'b1, 8'd7, 1'b0, 8'd1, 1'b0, 1'b1, 1'b0, "per_1");
    step(1'b0, 1'b0, 1'b1, 8'd7, 1'b0, 8'd3, 1'b1, 1'b1, 1'b0, "per_reload_a");
    step(1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 8'd2, 1'b0, 1'b1, 1'b0, "per_2b");
    step(1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 8'd1, 1'b0, 1'b1, 1'b0, "per_1b");
    step(1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 8'd3, 1'b1, 1'b1, 1'b0, "per_reload_b");
    step(1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 8'd2, 1'b0, 1'b1, 1'b0, "per_2c");

    // Reset mid-run, then IDLE ignores enable
    step(1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "reset_midrun");
    step(1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "idle_hold");

    // Pause at count 4
    step(1'b0, 1'b1, 1'b0, 8'd6, 1'b0, 8'd6, 1'b0, 1'b1, 1'b0, "pause_load6");
    step(1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 8'd5, 1'b0, 1'b1, 1'b0, "pause_5");
    step(1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 8'd4, 1'b0, 1'b1, 1'b0, "pause_4");
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'd4, 1'b0, 1'b1, 1'b0, "pause_hold");
    step(1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 8'd3, 1'b0, 1'b1, 1'b0, "resume_3");
    step(1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 8'd2, 1'b0, 1'b1, 1'b0, "resume_2");
    step(1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 8'd1, 1'b0, 1'b1, 1'b0, "resume_1");
    step(1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, "resume_expire");

    // Reload during RUN, then load zero
    step(1'b0, 1'b1, 1'b1, 8'd3, 1'b0, 8'd3, 1'b0, 1'b1, 1'b0, "rl_load3");
    step(1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 8'd2, 1'b0, 1'b1, 1'b0, "rl_2");
    step(1'b0, 1'b1, 1'b1, 8'd9, 1'b0, 8'd9, 1'b0, 1'b1, 1'b0, "rl_load9");
    step(1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 8'd8, 1'b0, 1'b1, 1'b0, "rl_8");
    step(1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "rl_load0");
    step(1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "rl_idle_hold");

    // Reset together with load at count 7
    step(1'b0, 1'b1, 1'b0, 8'd7, 1'b0, 8'd7, 1'b0, 1'b1, 1'b0, "rs_load7");
    step(1'b1, 1'b1, 1'b1, 8'd4, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "rs_reset_load");
    step(1'b0, 1'b1, 1'b0, 8'd2, 1'b0, 8'd2, 1'b0, 1'b1, 1'b0, "rs_load2");
    step(1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 8'd1, 1'b0, 1'b1, 1'b0, "rs_1");
    step(1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, "rs_expire");

    // Load from DONE: periodic with valor 1 pulses every enabled cycle
    step(1'b0, 1'b1, 1'b1, 8'd1, 1'b1, 8'd1, 1'b0, 1'b1, 1'b0, "p1_load1");
    step(1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 8'd1, 1'b1, 1'b1, 1'b0, "p1_tc_a");
    step(1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 8'd1, 1'b1, 1'b1, 1'b0, "p1_tc_b");
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'd1, 1'b0, 1'b1, 1'b0, "p1_pause");
    step(1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 8'd1, 1'b1, 1'b1, 1'b0, "p1_tc_c");

    @(negedge clk);
    load   = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/temporizador_8bits.md
TEMPORIZADOR_8BITS -- requirements
Module: temporizador_8bits

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, counter and load-value width in bits.
REQ-002 The block SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port enable, input, 1, count-down qualifier; high = decrement this cycle.
REQ-005 The block SHALL have port load, input, 1, one-cycle strobe capturing valor and modo.
REQ-006 The block SHALL have port valor, input, WIDTH, start/reload value.
REQ-007 The block SHALL have port modo, input, 1, 0 = one-shot, 1 = periodic (auto-reload).
REQ-008 The block SHALL have port count, output, WIDTH, current counter value (registered).
REQ-009 The block SHALL have port tc, output, 1, terminal-count pulse (registered, one cycle).
REQ-010 The block SHALL have port busy, output, 1, high while in state RUN.
REQ-011 The block SHALL have port done, output, 1, high while in state DONE (one-shot expired).

Function
REQ-012 The FSM SHALL have states IDLE, RUN, DONE; busy = (state==RUN), done = (state==DONE).
REQ-013 On load, the block SHALL capture valor into count and into an internal reload register, and capture modo into an internal mode register, in every state.
REQ-014 A load with valor!=0 SHALL move the FSM to RUN; a load with valor==0 SHALL set count=0, move to IDLE, and produce no tc.
REQ-015 load SHALL take priority over enable in the same cycle; no decrement occurs on a load cycle.
REQ-016 In RUN with enable=1 and count>1, count SHALL decrement by 1; with enable=0, count and state SHALL hold.
REQ-017 In RUN with enable=1, count==1 and registered mode 0, the block SHALL set count=0, assert tc for the next cycle only, and move to DONE.
REQ-018 In RUN with enable=1, count==1 and registered mode 1, the block SHALL set count=reload register, assert tc for the next cycle only, and stay in RUN; period = reload value in enabled cycles.
REQ-019 tc SHALL be high for exactly one cycle per expiry, coincident with the first cycle showing the post-expiry count (0 or reload value).
REQ-020 count SHALL never underflow or wrap below 0; in IDLE and DONE, count SHALL hold regardless of enable.
REQ-021 DONE SHALL persist, with count=0, until load or reset.
REQ-022 A change on modo or valor without load SHALL have no effect on the running sequence.
REQ-023 valor=1 in periodic mode SHALL produce tc every enabled cycle, with count constant at 1.

Reset
REQ-024 reset SHALL take priority over load and enable.
REQ-025 On reset, the block SHALL set count=0, tc=0, state=IDLE (busy=0, done=0), reload register=0, mode register=0 at the next rising edge.
REQ-026 A reset asserted mid-run SHALL abort the sequence with no tc emitted.

Verification
REQ-027 The bench SHALL cover reset for 1 cycle from arbitrary state -> count=0, tc=0, busy=0, done=0.
REQ-028 The bench SHALL cover load valor=5 modo=0, enable=1 held -> count 5,4,3,2,1,0; tc high only in the count=0 cycle; then busy=0, done=1, count holds 0.
REQ-029 The bench SHALL cover load valor=3 modo=1, enable=1 held -> count 3,2,1,3,2,1,3...; tc high in each cycle showing the reloaded 3, every 3 cycles; busy stays 1.
REQ-030 The bench SHALL cover load valor=6, then enable=0 for 4 cycles at count=4 -> count holds 4, no tc; on resume, tc arrives 4 enabled cycles later.
REQ-031 The bench SHALL cover load valor=9 during RUN at count=2 -> count=9 the next cycle, no tc; load valor=0 -> count=0, IDLE, no tc.
REQ-032 The bench SHALL cover reset and load asserted together at count=7 -> count=0, IDLE; the next load valor=2 modo=0 gives tc 2 enabled cycles later.
